// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//
// Contents:
//   WORD_DEFAULT  default datapath/PC width
//   PEND_*        bit positions of the write-back request/pending vector
//                 (0 = register file, 1 = memory, 2 = flags)
//   state_t       sequencer FSM state encoding (also exported on the debug
//                 state port)
//   retire_target state entered when an instruction retires
package stage_sequencer_pkg;

  localparam int WORD_DEFAULT = 16;

  localparam int PEND_W    = 3;
  localparam int PEND_REG  = 0;
  localparam int PEND_MEM  = 1;
  localparam int PEND_FLAG = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WB_WAIT = 3'd5,
    ST_PC_WB   = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  // Retirement is an action on a transition, not a state: the sequencer
  // goes straight on to the next fetch while run is held, else it idles.
  function automatic state_t retire_target(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/stage_sequencer_wb_tracker.sv
// wb_tracker: write-back bookkeeping for the instruction sequencer.
//
// Holds the pending write-back vector, emits the one-cycle write-back
// triggers and times out acknowledgement waits.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       high in the CHECK cycle: capture req, arm triggers, clear timer
//   active     high while the sequencer sits in WB_WAIT
//   req        write-back requests {flag, mem, reg}
//   ack        completion pulses   {flag, mem, reg}
//   trig       registered write-back triggers, high in the first WB_WAIT cycle
//   all_done   every pending bit is cleared, counting acks of this cycle
//   timeout    the last permitted WB_WAIT cycle passed without completion
module wb_tracker
  import stage_sequencer_pkg::*;
#(
  parameter int WB_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic [PEND_W-1:0] req,
  input  logic [PEND_W-1:0] ack,
  output logic [PEND_W-1:0] trig,
  output logic              all_done,
  output logic              timeout
);

  localparam int              CNT_W    = $clog2(WB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

  logic [PEND_W-1:0] pend;
  logic [CNT_W-1:0]  cnt;

  // Acks for bits that are not pending are masked out by pend itself, and
  // an ack arriving in the same cycle as its trigger already counts.
  assign all_done = (pend & ~ack) == '0;

  // cnt holds the number of WB_WAIT cycles already completed, so the wait
  // lasts exactly WB_TIMEOUT cycles. A completing ack in the final cycle
  // takes precedence over the timeout.
  assign timeout = active && !all_done && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      trig <= '0;
      cnt  <= '0;
    end else begin
      trig <= '0;
      if (load) begin
        pend <= req;
        trig <= req;
        cnt  <= '0;
      end else if (active) begin
        pend <= pend & ~ack;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: central instruction-sequencing controller.
//
// Steps every instruction through FETCH, DECODE, EXEC and CHECK, issues the
// register/memory/flag write-backs, waits for their acknowledgements and only
// then applies any PC redirect. Owns the architectural PC (a byte address;
// instructions are one word = 2 bytes) and the retired-instruction count.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   run                              keep issuing instructions while high
//   fetch_tr, reg_tr, dne_tr         stage triggers, high for FETCH/DECODE/EXEC
//   reg_wb_en, mem_wb_en,
//   flag_update_en                   write-back requests, sampled in CHECK
//   jump, rjump                      absolute / relative redirect, sampled in CHECK
//   jump_loc                         absolute target in words
//   jump_inc                         signed relative offset in words
//   reg_wb_tr, mem_wb_tr,
//   flag_update_tr                   one-cycle write-back triggers
//   reg_wb_ack, mem_wb_ack,
//   flag_update_ack                  write-back completion pulses
//   pc                               byte address of the current/next fetch
//   instr_cnt                        retired instruction count (wraps)
//   state                            current FSM state (debug)
//   halted                           high in HALT
//   err                              sticky write-back timeout flag
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int WORD       = WORD_DEFAULT,
  parameter int WB_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   fetch_tr,
  output logic                   reg_tr,
  output logic                   dne_tr,
  input  logic                   reg_wb_en,
  input  logic                   mem_wb_en,
  input  logic                   flag_update_en,
  input  logic                   jump,
  input  logic                   rjump,
  input  logic [WORD-1:0]        jump_loc,
  input  logic signed [WORD-1:0] jump_inc,
  output logic                   reg_wb_tr,
  output logic                   mem_wb_tr,
  output logic                   flag_update_tr,
  input  logic                   reg_wb_ack,
  input  logic                   mem_wb_ack,
  input  logic                   flag_update_ack,
  output logic [WORD-1:0]        pc,
  output logic [WORD-1:0]        instr_cnt,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   err
);

  state_t st;
  state_t st_nx;
  logic   retire;

  // Redirect captured in CHECK; jump wins over rjump.
  logic                   jmp_l;
  logic                   rj_l;
  logic [WORD-1:0]        loc_l;
  logic signed [WORD-1:0] inc_l;

  logic [PEND_W-1:0] wb_req;
  logic [PEND_W-1:0] wb_ack;
  logic [PEND_W-1:0] wb_trig;
  logic              all_done;
  logic              timeout;

  // Word count to byte offset; the top bit falls off, which is exactly the
  // modulo-2^WORD behaviour wanted for both targets and signed offsets.
  function automatic logic [WORD-1:0] words_to_bytes(input logic [WORD-1:0] w);
    return {w[WORD-2:0], 1'b0};
  endfunction

  // pc already points past the current instruction when PC_WB runs, so the
  // extra word added in DECODE is taken back out here.
  function automatic logic [WORD-1:0] rel_target(input logic [WORD-1:0] base,
                                                 input logic [WORD-1:0] inc);
    return base + words_to_bytes(inc) - WORD'(2);
  endfunction

  assign wb_req = {flag_update_en, mem_wb_en, reg_wb_en};
  assign wb_ack = {flag_update_ack, mem_wb_ack, reg_wb_ack};

  assign reg_wb_tr      = wb_trig[PEND_REG];
  assign mem_wb_tr      = wb_trig[PEND_MEM];
  assign flag_update_tr = wb_trig[PEND_FLAG];

  assign state = st;

  wb_tracker #(
    .WB_TIMEOUT(WB_TIMEOUT)
  ) u_wb_tracker (
    .clk      (clk),
    .rst      (rst),
    .load     (st == ST_CHECK),
    .active   (st == ST_WB_WAIT),
    .req      (wb_req),
    .ack      (wb_ack),
    .trig     (wb_trig),
    .all_done (all_done),
    .timeout  (timeout)
  );

  always_comb begin
    st_nx  = st;
    retire = 1'b0;
    case (st)
      ST_IDLE:    if (run) st_nx = ST_FETCH;
      ST_FETCH:   st_nx = ST_DECODE;
      ST_DECODE:  st_nx = ST_EXEC;
      ST_EXEC:    st_nx = ST_CHECK;
      ST_CHECK: begin
        if (wb_req != '0)       st_nx  = ST_WB_WAIT;
        else if (jump || rjump) st_nx  = ST_PC_WB;
        else                    retire = 1'b1;
      end
      ST_WB_WAIT: begin
        if (all_done) begin
          if (jmp_l || rj_l) st_nx  = ST_PC_WB;
          else               retire = 1'b1;
        end else if (timeout) begin
          st_nx = ST_HALT;
        end
      end
      ST_PC_WB:   retire = 1'b1;
      ST_HALT:    st_nx = ST_HALT;
    endcase
    if (retire) st_nx = retire_target(run);
  end

  // Stage triggers are registered copies of the next-state decode, so they
  // line up with the state register and never see an input combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      pc        <= '0;
      instr_cnt <= '0;
      jmp_l     <= 1'b0;
      rj_l      <= 1'b0;
      err       <= 1'b0;
      fetch_tr  <= 1'b0;
      reg_tr    <= 1'b0;
      dne_tr    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      st       <= st_nx;
      fetch_tr <= (st_nx == ST_FETCH);
      reg_tr   <= (st_nx == ST_DECODE);
      dne_tr   <= (st_nx == ST_EXEC);
      halted   <= (st_nx == ST_HALT);

      if (st == ST_DECODE) pc <= pc + WORD'(2);
      if (st == ST_PC_WB)  pc <= jmp_l ? words_to_bytes(loc_l) : rel_target(pc, inc_l);

      if (st == ST_CHECK) begin
        jmp_l <= jump;
        rj_l  <= rjump & ~jump;
      end

      if (retire)  instr_cnt <= instr_cnt + WORD'(1);
      if (timeout) err       <= 1'b1;
    end
  end

  // Redirect operands only matter once jmp_l/rj_l say so; no reset needed.
  always_ff @(posedge clk) begin
    if (st == ST_CHECK) begin
      loc_l <= jump_loc;
      inc_l <= jump_inc;
    end
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Central instruction-sequencing controller for the CPU. It drives the fetch, register-read and decode/execute stage triggers as one explicit FSM. It issues the reg, mem and flag write-back triggers, tracks their acknowledgements, and applies the PC write-back only after every other write-back has retired. It owns the architectural PC, sits between the stage units (mem, registers, execute) and the top-level cpu, and replaces ad-hoc trigger chaining.

## Interface
Parameters:
- WORD, default `WORD (16): datapath/PC width.
- WB_TIMEOUT, default 15: maximum cycles spent waiting for write-back acks before the error halt.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = keep issuing instructions, 0 = finish current instruction then idle.
- fetch_tr  out  1  high for the whole FETCH state.
- reg_tr  out  1  high for the whole DECODE state.
- dne_tr  out  1  high for the whole EXEC state.
- reg_wb_en, mem_wb_en, flag_update_en  in  1 each  write-back requests from execute, sampled in CHECK.
- jump, rjump  in  1 each  PC redirect requests, sampled in CHECK.
- jump_loc  in  WORD  absolute target, in words.
- jump_inc  in  WORD signed  relative offset, in words.
- reg_wb_tr, mem_wb_tr, flag_update_tr  out  1 each  one-cycle write-back triggers.
- reg_wb_ack, mem_wb_ack, flag_update_ack  in  1 each  completion pulses from the targets.
- pc  out  WORD  byte address of the current/next fetch.
- instr_cnt  out  WORD  count of retired instructions; wraps.
- state  out  3  current FSM state (debug).
- halted  out  1  high in the HALT state.
- err  out  1  sticky write-back timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, CHECK, WB_WAIT, PC_WB, HALT.
- IDLE -> FETCH when run=1.
- FETCH -> DECODE.
- DECODE: pc <= pc+2, mod 2^WORD. -> EXEC.
- EXEC -> CHECK.
- CHECK:
  - Latch pend = {flag_update_en, mem_wb_en, reg_wb_en}.
  - Latch jmp_l = jump and rj_l = rjump & ~jump; jump has priority.
  - Load the ack timeout counter with 0.
  - If pend != 0 -> WB_WAIT. Else if jmp_l|rj_l -> PC_WB. Else -> RETIRE action.
- WB_WAIT:
  - Triggers for the set pend bits are asserted in the first WB_WAIT cycle only.
  - Each ack clears its pend bit. An ack in the same cycle as its trigger is valid.
  - Acks for bits not pending are ignored.
  - When pend becomes 0: -> PC_WB if jmp_l|rj_l, else RETIRE.
  - If the counter reaches WB_TIMEOUT with pend != 0: err <= 1, -> HALT.
- PC_WB:
  - If jmp_l: pc <= jump_loc<<1.
  - Else (rj_l): pc <= pc + (jump_inc<<1) - 2.
  - All arithmetic is modulo 2^WORD; jump_inc is sign-extended and wrap is silent.
  - Then RETIRE.
- RETIRE (a transition action, not a state): instr_cnt += 1. -> FETCH if run, else IDLE.
- HALT: absorbing; exit only via rst.
- Reset values:
  - state=IDLE, pc=0, instr_cnt=0, pend=0, err=0.
  - All trigger outputs 0; halted=0.

## Timing
- Trigger outputs are registered, or decoded from the registered state; no input-to-output combinational path.
- Instruction with no write-back and no jump: 4 cycles (FETCH, DECODE, EXEC, CHECK), then FETCH.
- Write-backs with immediate ack: 5 cycles. With a jump added: 6 cycles.
- pc updates at the end of DECODE (+2) and at the end of PC_WB. It never updates while pend != 0.
- run is sampled only at RETIRE and in IDLE. Deasserting run mid-instruction completes that instruction, including PC_WB.
- rst asserted mid-operation immediately forces reset values. Pending write-backs are abandoned and no trigger is emitted after rst.
- Simultaneous ack and timeout in the same cycle: the ack wins. If pend clears, there is no error.

## Structure
- The state encoding and the pend bit positions (0=reg, 1=mem, 2=flag) go as `define constants in a shared header, stage_defs.v, included alongside fmt.v.
- One sub-module, wb_tracker, holds pend, the trigger pulse generation, ack clearing and the timeout counter. It exposes an all_done signal and a timeout signal to the FSM.

## Test plan
- NOP stream:
  - Stimulus: run=1, all enables 0.
  - Required: fetch_tr every 4 cycles; pc = 0,2,4,6; instr_cnt=3 after 12 cycles.
- Single write-back:
  - Stimulus: reg_wb_en=1 in CHECK, reg_wb_ack in the trigger cycle.
  - Required: reg_wb_tr is exactly one cycle; next fetch_tr 5 cycles after the previous one.
- Ordering of PC after write-backs:
  - Stimulus: mem+flag requested with jump=1, jump_loc=5; flag_ack 1 cycle late, mem_ack 3 cycles late.
  - Required: pc stays 2 until after the mem ack, then becomes 10; then FETCH.
- Relative jump:
  - Stimulus: rjump=1, jump_inc=-3 at pc=8 (pc=10 after DECODE).
  - Required: pc=10-6-2=2.
  - Also: with both jump and rjump set, jump wins.
- Timeout:
  - Stimulus: reg_wb_en=1, never ack.
  - Required: err=1 and halted=1 after WB_TIMEOUT cycles in WB_WAIT; pc unchanged.
- Reset and stop:
  - Stimulus: rst pulse mid-WB_WAIT.
  - Required: next cycle state=IDLE, pc=0, no triggers.
  - Stimulus: run dropped in DECODE.
  - Required: instruction retires, then IDLE, with no further fetch_tr.
